// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: issues one load/store on a req/gnt + rvalid bus,
// stalls the pipeline while it is outstanding and reports completion or a one-cycle fault.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_strb_i,
    input  logic        misaligned_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_strb_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_DRAIN} state_t;
    typedef enum logic [1:0] {FC_NONE, FC_MISALIGN, FC_TIMEOUT, FC_BUSERR} fault_code_t;

    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_n;
    fault_code_t      code_n;
    logic [CNT_W-1:0] cnt;
    logic             bus_req_n, done_n, accept, capture, cnt_clr, timeout_hit;

    assign timeout_hit = TO_EN && (cnt == TO_LAST);

    // NOTE: every registered signal uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_n;
    end

    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
    always_comb begin
        state_n   = state;
        code_n    = FC_NONE;
        bus_req_n = 1'b0;
        done_n    = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        cnt_clr   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    accept = 1'b1;
                    if (misaligned_i) begin
                        state_n = S_RESP;
                        done_n  = 1'b1;
                        code_n  = FC_MISALIGN;
                    end else begin
                        state_n   = S_REQ;
                        bus_req_n = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (bus_gnt_i) begin
                    cnt_clr = 1'b1;
                    state_n = flush_i ? S_DRAIN : S_WAIT;
                end else if (flush_i) begin
                    state_n = S_IDLE;
                end else begin
                    bus_req_n = 1'b1;
                end
            end
            S_WAIT: begin
                // A response in the timeout cycle still completes the access normally.
                if (bus_rvalid_i) begin
                    capture = 1'b1;
                    state_n = S_RESP;
                    done_n  = 1'b1;
                    code_n  = bus_err_i ? FC_BUSERR : FC_NONE;
                end else if (flush_i) begin
                    state_n = S_DRAIN;
                end else if (timeout_hit) begin
                    state_n = S_RESP;
                    done_n  = 1'b1;
                    code_n  = FC_TIMEOUT;
                end
            end
            S_RESP:  state_n = S_IDLE;
            S_DRAIN: if (bus_rvalid_i) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else if (state == S_WAIT) cnt <= cnt + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus_req_o    <= 1'b0;
            done_o       <= 1'b0;
            fault_o      <= 1'b0;
            fault_code_o <= 2'b00;
            rdata_o      <= '0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
            bus_strb_o   <= '0;
        end else begin
            bus_req_o    <= bus_req_n;
            done_o       <= done_n;
            fault_o      <= (code_n != FC_NONE);
            fault_code_o <= code_n;
            if (capture) rdata_o <= bus_rdata_i;
            // Bus fields are taken once at accept and stay put until the next accept.
            if (accept) begin
                bus_we_o    <= req_we_i;
                bus_addr_o  <= {req_addr_i[31:2], 2'b00};
                bus_wdata_o <= req_wdata_i;
                bus_strb_o  <= req_strb_i;
            end
        end
    end

    assign stall_o = ((state == S_IDLE) && req_valid_i && !flush_i) ||
                     (state == S_REQ) || (state == S_WAIT) || (state == S_DRAIN);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT_CYCLES=4; each task drives one scenario
// and compares outputs against hand-computed values.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, misaligned, flush;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic        stall, done, fault, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
    logic [1:0]  fault_code;
    logic [3:0]  bus_strb;
    logic        bus_gnt, bus_rvalid, bus_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_strb_i(req_strb), .misaligned_i(misaligned),
        .flush_i(flush), .stall_o(stall), .done_o(done), .rdata_o(rdata),
        .fault_o(fault), .fault_code_o(fault_code),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_strb_o(bus_strb),
        .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
        .bus_err_i(bus_err)
    );

    // Advance to just after the next rising edge; registered outputs are then settled.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input logic mis);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        req_strb = strb; misaligned = mis;
    endtask

    // Plain aligned load: gnt in cycle 1, rvalid in cycle 2, samples cycle 3.
    task automatic run_load(input logic [31:0] addr, input logic [31:0] data, input logic err,
                            output logic d, output logic f, output logic [1:0] code,
                            output logic [31:0] rd);
        issue(1'b0, addr, 32'h0, 4'hF, 1'b0);
        tick(); req_valid = 1'b0; bus_gnt = 1'b1;
        tick(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = data; bus_err = err;
        tick(); bus_rvalid = 1'b0; bus_err = 1'b0;
        d = done; f = fault; code = fault_code; rd = rdata;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_strb = 0;
        misaligned = 0; flush = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
        tick(); tick();
        checks++; if ({stall, done, fault, bus_req, bus_we} !== 5'b0) begin
            failures++; $display("FAIL reset_ctl got=%b exp=00000", {stall, done, fault, bus_req, bus_we}); end
        checks++; if (fault_code !== 2'b00) begin
            failures++; $display("FAIL reset_code got=%b exp=00", fault_code); end
        checks++; if ({rdata, bus_addr, bus_wdata, bus_strb} !== 100'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {rdata, bus_addr, bus_wdata, bus_strb}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load();
        issue(1'b0, 32'h104, 32'h0, 4'hF, 1'b0);
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL load_stall_c0 got=%b exp=1", stall); end
        tick(); req_valid = 1'b0; bus_gnt = 1'b1;
        checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL load_req_c1 got=%b exp=1", bus_req); end
        checks++; if (bus_addr !== 32'h104) begin failures++; $display("FAIL load_addr got=%h exp=00000104", bus_addr); end
        checks++; if (bus_we !== 1'b0) begin failures++; $display("FAIL load_we got=%b exp=0", bus_we); end
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL load_stall_c1 got=%b exp=1", stall); end
        tick(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
        checks++; if ({bus_req, done, stall} !== 3'b001) begin
            failures++; $display("FAIL load_c2 req_done_stall got=%b exp=001", {bus_req, done, stall}); end
        tick(); bus_rvalid = 1'b0;
        checks++; if ({done, fault, stall} !== 3'b100) begin
            failures++; $display("FAIL load_c3 done_fault_stall got=%b exp=100", {done, fault, stall}); end
        checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", rdata); end
        checks++; if (fault_code !== 2'b00) begin failures++; $display("FAIL load_code got=%b exp=00", fault_code); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL load_done_c4 got=%b exp=0", done); end
    endtask

    task automatic test_store_gnt_delay();
        int ndone = 0;
        issue(1'b1, 32'h20B, 32'h11223344, 4'b1100, 1'b0);
        tick(); req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL st_req c%0d got=%b exp=1", i, bus_req); end
            checks++; if (bus_we !== 1'b1) begin failures++; $display("FAIL st_we c%0d got=%b exp=1", i, bus_we); end
            checks++; if (bus_addr !== 32'h208) begin failures++; $display("FAIL st_addr c%0d got=%h exp=00000208", i, bus_addr); end
            checks++; if (bus_wdata !== 32'h11223344) begin failures++; $display("FAIL st_wdata c%0d got=%h exp=11223344", i, bus_wdata); end
            checks++; if (bus_strb !== 4'b1100) begin failures++; $display("FAIL st_strb c%0d got=%b exp=1100", i, bus_strb); end
            bus_gnt = (i == 4);
            tick();
        end
        bus_gnt = 1'b0;
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL st_req_wait got=%b exp=0", bus_req); end
        for (int j = 0; j < 6; j++) begin
            bus_rvalid = (j == 1);
            tick();
            if (done === 1'b1) ndone++;
        end
        bus_rvalid = 1'b0;
        checks++; if (ndone != 1) begin failures++; $display("FAIL st_done_count got=%0d exp=1", ndone); end
    endtask

    task automatic test_misaligned();
        issue(1'b0, 32'h102, 32'h0, 4'hF, 1'b1);
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mis_stall_c0 got=%b exp=1", stall); end
        tick(); req_valid = 1'b0; misaligned = 1'b0;
        checks++; if ({done, fault, bus_req} !== 3'b110) begin
            failures++; $display("FAIL mis_c1 done_fault_req got=%b exp=110", {done, fault, bus_req}); end
        checks++; if (fault_code !== 2'b01) begin failures++; $display("FAIL mis_code got=%b exp=01", fault_code); end
        tick();
        checks++; if ({done, fault, bus_req, fault_code} !== 5'b0) begin
            failures++; $display("FAIL mis_c2 got=%b exp=00000", {done, fault, bus_req, fault_code}); end
    endtask

    task automatic test_timeout();
        logic d, f; logic [1:0] c; logic [31:0] rd;
        issue(1'b0, 32'h300, 32'h0, 4'hF, 1'b0);
        tick(); req_valid = 1'b0; bus_gnt = 1'b1;
        tick(); bus_gnt = 1'b0;
        tick(); tick(); tick();
        checks++; if ({done, stall} !== 2'b01) begin
            failures++; $display("FAIL to_c5 done_stall got=%b exp=01", {done, stall}); end
        tick(); bus_rvalid = 1'b1; bus_rdata = 32'h5555AAAA;
        checks++; if ({done, fault, stall} !== 3'b110) begin
            failures++; $display("FAIL to_resp done_fault_stall got=%b exp=110", {done, fault, stall}); end
        checks++; if (fault_code !== 2'b10) begin failures++; $display("FAIL to_code got=%b exp=10", fault_code); end
        tick();
        checks++; if ({done, stall, bus_req} !== 3'b000) begin
            failures++; $display("FAIL to_late1 got=%b exp=000", {done, stall, bus_req}); end
        tick(); bus_rvalid = 1'b0;
        checks++; if ({done, fault} !== 2'b00) begin
            failures++; $display("FAIL to_late2 got=%b exp=00", {done, fault}); end
        run_load(32'h400, 32'h0BADF00D, 1'b0, d, f, c, rd);
        checks++; if ({d, f, c} !== 4'b1000) begin failures++; $display("FAIL to_next got=%b exp=1000", {d, f, c}); end
        checks++; if (rd !== 32'h0BADF00D) begin failures++; $display("FAIL to_next_rdata got=%h exp=0badf00d", rd); end
    endtask

    task automatic test_rvalid_at_timeout();
        issue(1'b0, 32'h500, 32'h0, 4'hF, 1'b0);
        tick(); req_valid = 1'b0; bus_gnt = 1'b1;
        tick(); bus_gnt = 1'b0;
        tick(); tick(); tick(); bus_rvalid = 1'b1; bus_rdata = 32'hCAFE0001;
        tick(); bus_rvalid = 1'b0;
        checks++; if ({done, fault, fault_code} !== 4'b1000) begin
            failures++; $display("FAIL rvto_resp got=%b exp=1000", {done, fault, fault_code}); end
        checks++; if (rdata !== 32'hCAFE0001) begin failures++; $display("FAIL rvto_rdata got=%h exp=cafe0001", rdata); end
        tick();
    endtask

    task automatic test_flush_drain();
        logic seen = 1'b0;
        issue(1'b0, 32'h600, 32'h0, 4'hF, 1'b0);
        tick(); req_valid = 1'b0; bus_gnt = 1'b1;
        tick(); bus_gnt = 1'b0; flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fl_stall_c2 got=%b exp=1", stall); end
        tick(); flush = 1'b0; seen = seen | done;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fl_stall_c3 got=%b exp=1", stall); end
        tick(); seen = seen | done; bus_rvalid = 1'b1; bus_rdata = 32'h77777777;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fl_stall_c4 got=%b exp=1", stall); end
        tick(); bus_rvalid = 1'b0; seen = seen | done | fault;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fl_stall_c5 got=%b exp=0", stall); end
        tick(); seen = seen | done | fault;
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL fl_no_done got=%b exp=0", seen); end
    endtask

    task automatic test_flush_in_req();
        issue(1'b1, 32'h700, 32'h12345678, 4'b0011, 1'b0);
        tick(); req_valid = 1'b0; flush = 1'b1;
        checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL flr_req_c1 got=%b exp=1", bus_req); end
        tick(); flush = 1'b0;
        checks++; if ({bus_req, stall, done} !== 3'b000) begin
            failures++; $display("FAIL flr_c2 req_stall_done got=%b exp=000", {bus_req, stall, done}); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL flr_c3_done got=%b exp=0", done); end
    endtask

    task automatic test_bus_error();
        logic d, f; logic [1:0] c; logic [31:0] rd;
        run_load(32'h800, 32'hBAD0BAD0, 1'b1, d, f, c, rd);
        checks++; if ({d, f} !== 2'b11) begin failures++; $display("FAIL err_done_fault got=%b exp=11", {d, f}); end
        checks++; if (c !== 2'b11) begin failures++; $display("FAIL err_code got=%b exp=11", c); end
    endtask

    task automatic test_reset_mid_wait();
        logic d, f; logic [1:0] c; logic [31:0] rd;
        issue(1'b1, 32'h904, 32'hA5A5A5A5, 4'hF, 1'b0);
        tick(); req_valid = 1'b0; bus_gnt = 1'b1;
        tick(); bus_gnt = 1'b0;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rstw_pre_stall got=%b exp=1", stall); end
        rst = 1'b1;
        #1;
        checks++; if ({stall, done, fault, bus_req, bus_we, fault_code} !== 7'b0) begin
            failures++; $display("FAIL rstw_ctl got=%b exp=0000000", {stall, done, fault, bus_req, bus_we, fault_code}); end
        checks++; if ({rdata, bus_addr, bus_wdata, bus_strb} !== 100'h0) begin
            failures++; $display("FAIL rstw_data got=%h exp=0", {rdata, bus_addr, bus_wdata, bus_strb}); end
        tick(); rst = 1'b0;
        tick();
        checks++; if ({stall, done} !== 2'b00) begin failures++; $display("FAIL rstw_after got=%b exp=00", {stall, done}); end
        run_load(32'hA00, 32'h01020304, 1'b0, d, f, c, rd);
        checks++; if ({d, f, rd} !== {2'b10, 32'h01020304}) begin
            failures++; $display("FAIL rstw_recover got=%b/%h exp=10/01020304", {d, f}, rd); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load();
        test_store_gnt_delay();
        test_misaligned();
        test_timeout();
        test_rvalid_at_timeout();
        test_flush_drain();
        test_flush_in_req();
        test_bus_error();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
